// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the memory-mapped character-LCD controller:
//   - register offsets inside the 4-word device window
//   - STATUS / control bit positions
//   - transfer FSM state encoding
//   - small elaboration-time helper for sizing the phase counter
// ---------------------------------------------------------------------------
package lcd_pkg;

    // Register offsets relative to the window base (byte offsets, word aligned)
    localparam logic [31:0] LCD_OFF_DATA   = 32'h0;
    localparam logic [31:0] LCD_OFF_CMD    = 32'h4;
    localparam logic [31:0] LCD_OFF_STATUS = 32'h8;
    localparam logic [31:0] LCD_OFF_RAW    = 32'hC;

    // STATUS read-back bit positions
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_IE      = 4;
    localparam int STAT_CNT_LSB = 8;

    // STATUS write-side control bits (bit 4 writes IE, shared with STAT_IE)
    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

    // Transfer sequence: one strobe per FIFO entry
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_GAP
    } lcd_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead output (dout is the head entry whenever
// empty=0). A push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle; otherwise it is ignored. flush empties the FIFO and
// overrides any push/pop in the same cycle.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   push, din    write request and entry
//   pop          read request; advances the head
//   flush        discard all entries
//   dout         head entry
//   full, empty  occupancy flags
//   count        occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra MSB on each pointer separates "full" from "empty" when the
    // index bits coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; its contents are never observed
    // before being written because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/lcd_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_mmio_ctrl
// Memory-mapped character-LCD controller. CPU writes to DATA/CMD are queued
// in a FIFO; each entry is replayed on the parallel LCD bus as
//   SETUP (E low) -> PULSE (E high) -> HOLD (E low) -> GAP (settle)
// with the settle gap chosen by the entry type (commands are slow).
// A free-running 32-bit RAW register drives lcd_raw for direct-drive rigs.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   device_address        CPU byte address (addr[1:0] ignored)
//   device_input          CPU write data
//   device_write_enable   single-cycle write strobe
//   device_read_enable    single-cycle read strobe
//   device_output         registered read data, held between reads
//   lcd_data, lcd_rs      LCD data bus and register select (1 = data)
//   lcd_e                 LCD enable strobe
//   lcd_raw               RAW register value
//   irq                   level interrupt: IE & FIFO empty & idle
// ---------------------------------------------------------------------------
module lcd_mmio_ctrl
    import lcd_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h28,
    parameter int          FIFO_DEPTH = 8,
    parameter int          LCD_WIDTH  = 8,
    parameter int          SETUP_CYC  = 2,
    parameter int          E_CYC      = 4,
    parameter int          HOLD_CYC   = 2,
    parameter int          GAP_DATA   = 8,
    parameter int          GAP_CMD    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          device_address,
    input  logic [31:0]          device_input,
    input  logic                 device_write_enable,
    input  logic                 device_read_enable,
    output logic [31:0]          device_output,
    output logic [LCD_WIDTH-1:0] lcd_data,
    output logic                 lcd_rs,
    output logic                 lcd_e,
    output logic [31:0]          lcd_raw,
    output logic                 irq
);

    localparam int CNT_MAX = max_int(max_int(max_int(SETUP_CYC, E_CYC), max_int(HOLD_CYC, GAP_DATA)), GAP_CMD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [31:0] offset;
    logic        sel_data, sel_cmd, sel_status, sel_raw;
    logic        wr_data, wr_cmd, wr_status, wr_raw;
    logic        push_req, flush;

    // Masking the byte-lane bits makes any addr[1:0] alias the same word.
    assign offset     = (device_address & 32'hFFFF_FFFC) - BASE_ADDR;
    assign sel_data   = (offset == LCD_OFF_DATA);
    assign sel_cmd    = (offset == LCD_OFF_CMD);
    assign sel_status = (offset == LCD_OFF_STATUS);
    assign sel_raw    = (offset == LCD_OFF_RAW);

    assign wr_data    = device_write_enable & sel_data;
    assign wr_cmd     = device_write_enable & sel_cmd;
    assign wr_status  = device_write_enable & sel_status;
    assign wr_raw     = device_write_enable & sel_raw;

    assign push_req   = wr_data | wr_cmd;
    assign flush      = wr_status & device_input[CTRL_FLUSH];

    // ------------------------------------------------------------------
    // Entry FIFO: {rs, data}
    // ------------------------------------------------------------------
    logic [LCD_WIDTH:0]   fifo_din;
    logic [LCD_WIDTH:0]   fifo_dout;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    assign fifo_din  = {wr_data, device_input[LCD_WIDTH-1:0]};
    // A flush in the same cycle swallows the push silently.
    assign fifo_push = push_req & ~flush;

    sync_fifo #(
        .WIDTH (LCD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Transfer FSM with a single shared phase down-counter
    // ------------------------------------------------------------------
    lcd_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] gap_len;

    // lcd_rs already holds the type of the entry in flight.
    assign gap_len = lcd_rs ? CNT_W'(GAP_DATA) : CNT_W'(GAP_CMD);

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fifo_pop = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_nx = ST_SETUP;
                    cnt_nx   = CNT_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nx = ST_PULSE;
                    cnt_nx   = CNT_W'(E_CYC - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    if (gap_len == '0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_GAP;
                        cnt_nx   = gap_len - CNT_W'(1);
                    end
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // lcd_e is registered from the next state so the strobe is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            lcd_e <= (state_nx == ST_PULSE);
            if (fifo_pop) {lcd_rs, lcd_data} <= fifo_dout;
        end
    end

    // ------------------------------------------------------------------
    // Control/status registers and read port
    // ------------------------------------------------------------------
    logic        ovf;
    logic        ie;
    logic        busy;
    logic [31:0] status_word;
    logic [31:0] rd_mux;

    assign busy = (state != ST_IDLE);
    assign irq  = ie & fifo_empty & ~busy;

    always_comb begin
        status_word                        = '0;
        status_word[STAT_CNT_LSB +: 8]     = 8'(fifo_count);
        status_word[STAT_IE]               = ie;
        status_word[STAT_OVF]              = ovf;
        status_word[STAT_BUSY]             = busy;
        status_word[STAT_FULL]             = fifo_full;
        status_word[STAT_EMPTY]            = fifo_empty;
    end

    // DATA/CMD and unmapped offsets read as zero.
    always_comb begin
        rd_mux = '0;
        if (sel_status)   rd_mux = status_word;
        else if (sel_raw) rd_mux = lcd_raw;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf           <= 1'b0;
            ie            <= 1'b0;
            lcd_raw       <= '0;
            device_output <= '0;
        end else begin
            // Reads see pre-write values because rd_mux is built from flops.
            if (device_read_enable) device_output <= rd_mux;
            if (wr_raw) lcd_raw <= device_input;
            if (wr_status) ie <= device_input[STAT_IE];
            if (wr_status && device_input[CTRL_CLR_OVF]) begin
                ovf <= 1'b0;
            end else if (fifo_push && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_mmio_ctrl
// Directed scenarios followed by randomized bus traffic. A transaction-level
// reference model (entry queue plus "cycles since pop" timer) predicts every
// output each cycle; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lcd_mmio_ctrl;

    localparam logic [31:0] BASE  = 32'h28;
    localparam int          DEPTH = 8;
    localparam int          S     = 2;
    localparam int          E     = 4;
    localparam int          H     = 2;
    localparam int          GD    = 8;
    localparam int          GC    = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] device_address = '0;
    logic [31:0] device_input = '0;
    logic        device_write_enable = 1'b0;
    logic        device_read_enable = 1'b0;
    logic [31:0] device_output;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_e;
    logic [31:0] lcd_raw;
    logic        irq;

    lcd_mmio_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .device_address      (device_address),
        .device_input        (device_input),
        .device_write_enable (device_write_enable),
        .device_read_enable  (device_read_enable),
        .device_output       (device_output),
        .lcd_data            (lcd_data),
        .lcd_rs              (lcd_rs),
        .lcd_e               (lcd_e),
        .lcd_raw             (lcd_raw),
        .irq                 (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [8:0]  m_q[$];
    bit          m_ovf, m_ie, m_xfer, m_rs;
    int          m_t;
    logic [7:0]  m_data;
    logic [31:0] m_raw, m_dout;

    function automatic int xfer_len(input bit rs);
        return S + E + H + (rs ? GD : GC);
    endfunction

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(m_q.size()), 3'b000, m_ie, m_ovf, m_xfer,
                m_q.size() == DEPTH, m_q.size() == 0};
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_ovf = 0; m_ie = 0; m_xfer = 0; m_rs = 0; m_t = 0;
        m_data = '0; m_raw = '0; m_dout = '0;
    endfunction

    function automatic void model_clock();
        logic [31:0] off;
        int          n_pre;
        bit          popped;
        bit          do_flush;
        off      = {device_address[31:2], 2'b00} - BASE;
        n_pre    = m_q.size();
        popped   = 0;
        do_flush = 0;
        if (device_read_enable) begin
            case (off)
                32'h8:   m_dout = m_status();
                32'hC:   m_dout = m_raw;
                default: m_dout = '0;
            endcase
        end
        if (m_xfer) begin
            m_t++;
            if (m_t >= xfer_len(m_rs)) m_xfer = 0;
        end else if (n_pre > 0) begin
            {m_rs, m_data} = m_q.pop_front();
            m_xfer = 1;
            m_t    = 0;
            popped = 1;
        end
        if (device_write_enable) begin
            if (off == 32'h0 || off == 32'h4) begin
                if (n_pre == DEPTH && !popped) m_ovf = 1;
                else m_q.push_back({off == 32'h0, device_input[7:0]});
            end else if (off == 32'h8) begin
                do_flush = device_input[0];
                if (device_input[1]) m_ovf = 0;
                m_ie = device_input[4];
            end else if (off == 32'hC) begin
                m_raw = device_input;
            end
        end
        if (do_flush) m_q.delete();
    endfunction

    always @(posedge clk) if (reset === 1'b1) model_clock();

    task automatic compare_all();
        bit exp_e;
        bit exp_irq;
        exp_e   = m_xfer && (m_t >= S) && (m_t < S + E);
        exp_irq = m_ie && (m_q.size() == 0) && !m_xfer;
        check("lcd_e", lcd_e, exp_e);
        check("lcd_rs", lcd_rs, m_rs);
        check("lcd_data", lcd_data, m_data);
        check("lcd_raw", lcd_raw, m_raw);
        check("device_output", device_output, m_dout);
        check("irq", irq, exp_irq);
    endtask

    // One bus cycle: drive after a falling edge, compare at the next one.
    task automatic step(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
        device_write_enable = we;
        device_read_enable  = re;
        device_address      = a;
        device_input        = d;
        @(negedge clk);
        device_write_enable = 1'b0;
        device_read_enable  = 1'b0;
        compare_all();
    endtask

    // Idle cycles with a record of E rises, high cycles and irq rises.
    int         w_rise[$];
    logic [8:0] w_ent[$];
    int         w_irq_rise[$];
    int         w_high;

    task automatic watch(input int n);
        bit pe;
        bit pi;
        pe = lcd_e;
        pi = irq;
        w_rise.delete();
        w_ent.delete();
        w_irq_rise.delete();
        w_high = 0;
        for (int k = 0; k < n; k++) begin
            step(0, 0, 32'h0, 32'h0);
            if (lcd_e) w_high++;
            if (lcd_e && !pe) begin
                w_rise.push_back(k);
                w_ent.push_back({lcd_rs, lcd_data});
            end
            if (irq && !pi) w_irq_rise.push_back(k);
            pe = lcd_e;
            pi = irq;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hi;

        // 1. reset state and STATUS read
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_e_async", lcd_e, 0);
        reset = 1'b1;
        @(negedge clk);
        compare_all();
        step(0, 1, 32'h30, 32'h0);
        check("t1_status", device_output, 32'h0000_0001);
        check("t1_raw", lcd_raw, 32'h0);

        // 2. single data write: strobe timing and busy window (IE on for irq)
        step(1, 0, 32'h30, 32'h10);
        step(1, 0, 32'h28, 32'h41);
        watch(30);
        check("t2_rises", w_rise.size(), 1);
        if (w_rise.size() == 1) begin
            check("t2_rise_k", w_rise[0], S);
            check("t2_entry", w_ent[0], {1'b1, 8'h41});
        end
        check("t2_e_high", w_high, E);
        check("t2_irq_rises", w_irq_rise.size(), 1);
        if (w_irq_rise.size() == 1) check("t2_busy_len", w_irq_rise[0], S + E + H + GD);

        // 3. command then data: second strobe waits out the command gap
        step(1, 0, 32'h2C, 32'h01);
        step(1, 0, 32'h28, 32'h42);
        watch(150);
        check("t3_rises", w_rise.size(), 2);
        if (w_rise.size() == 2) begin
            check("t3_spacing", w_rise[1] - w_rise[0], S + E + H + GC + 1);
            check("t3_first", w_ent[0], {1'b0, 8'h01});
            check("t3_second", w_ent[1], {1'b1, 8'h42});
        end

        // 4. fill, overflow, clear overflow
        for (int i = 0; i < 9; i++) step(1, 0, 32'h28, 32'h60 + i);
        step(0, 1, 32'h30, 32'h0);
        check("t4_nine", device_output, 32'h0000_0816);
        step(1, 0, 32'h28, 32'h70);
        step(0, 1, 32'h30, 32'h0);
        check("t4_ovf", device_output, 32'h0000_081E);
        step(1, 0, 32'h30, 32'h12);
        step(0, 1, 32'h30, 32'h0);
        check("t4_ovf_clr", device_output, 32'h0000_0816);
        step(1, 0, 32'h30, 32'h11);
        watch(100);
        step(0, 1, 32'h30, 32'h0);
        check("t4_drained", device_output, 32'h0000_0011);

        // 5. flush during PULSE
        for (int i = 0; i < 4; i++) step(1, 0, 32'h28, 32'hA0 + i);
        for (int k = 0; k < 20 && !lcd_e; k++) step(0, 0, 32'h0, 32'h0);
        check("t5_in_pulse", lcd_e, 1);
        hi = 1;
        step(1, 0, 32'h30, 32'h11);
        if (lcd_e) hi++;
        watch(200);
        check("t5_e_total", hi + w_high, E);
        check("t5_no_rises", w_rise.size(), 0);
        step(0, 1, 32'h30, 32'h0);
        check("t5_count", device_output[15:8], 0);

        // 6. RAW register and asynchronous reset mid-PULSE
        step(1, 0, 32'h34, 32'hDEAD_BEEF);
        check("t6_raw", lcd_raw, 32'hDEAD_BEEF);
        step(0, 1, 32'h37, 32'h0);
        check("t6_raw_rd", device_output, 32'hDEAD_BEEF);
        step(1, 0, 32'h28, 32'h55);
        for (int k = 0; k < 20 && !lcd_e; k++) step(0, 0, 32'h0, 32'h0);
        check("t6_in_pulse", lcd_e, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_e", lcd_e, 0);
        check("t6_rst_raw", lcd_raw, 0);
        check("t6_rst_rs", lcd_rs, 0);
        check("t6_rst_data", lcd_data, 0);
        check("t6_rst_dout", device_output, 0);
        check("t6_rst_irq", irq, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compare_all();

        // 7. randomized traffic, including unmapped offsets and read/write overlap
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            bit          we;
            bit          re;
            a  = 32'h24 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            d  = $urandom();
            we = ($urandom_range(0, 9) < 3);
            re = ($urandom_range(0, 3) == 0);
            if (a[31:2] == 30'hC) d[0] = ($urandom_range(0, 5) == 0);
            step(we, re, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
